pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 149 ++++++++++++++
 tb/tb_pipe_chain.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// -----------------------------------------------------------------------------
// pipe_chain
//   A DEPTH-stage valid/ready register pipeline. Each stage holds a valid bit
//   and a WIDTH-bit payload. A stage accepts a new word whenever it is empty or
//   anything downstream of it can move, so bubbles collapse. Per-stage flush
//   bits kill whatever a stage would hold after the edge, without touching
//   the ready chain.
//
//   Optional feature macro: PIPE_CHAIN_PERF_EN
//     defined   -> occupancy_o is the registered count of valid stages and
//                  stall_cnt_o counts out_valid_o & !out_ready_i cycles
//                  (saturating).
//     undefined -> both ports are tied to 0 and no counter logic exists.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous, active-high reset
//   in_valid_i   : upstream word offered
//   in_data_i    : upstream payload [WIDTH]
//   in_ready_o   : stage 0 accepts this cycle
//   out_valid_o  : last stage holds a valid word
//   out_data_o   : payload of the last stage [WIDTH]
//   out_ready_i  : downstream accepts
//   flush_i      : per-stage kill, bit k targets stage k [DEPTH]
//   occupancy_o  : number of valid stages [$clog2(DEPTH+1)]
//   stall_cnt_o  : backpressure cycle count [32]
// -----------------------------------------------------------------------------
module pipe_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   input  logic [WIDTH-1:0]           in_data_i,
   output logic                       in_ready_o,
   output logic                       out_valid_o,
   output logic [WIDTH-1:0]           out_data_o,
   input  logic                       out_ready_i,
   input  logic [DEPTH-1:0]           flush_i,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
   output logic [31:0]                stall_cnt_o
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];

   logic [DEPTH:0]   rdy;
   logic [DEPTH:0]   chain_v;
   logic [WIDTH-1:0] src_d [DEPTH];

   // Ready ripples from the consumer back to stage 0. A running variable keeps
   // the chain a single forward computation rather than a self-referencing
   // vector.
   always_comb begin : ready_chain
      logic r;
      r          = out_ready_i;
      rdy        = '0;
      rdy[DEPTH] = r;
      for (int k = DEPTH-1; k >= 0; k--) begin
         r      = ~v_q[k] | r;
         rdy[k] = r;
      end
   end

   // Word offered to each stage: stage 0 from upstream, stage k from k-1.
   assign chain_v = {v_q, in_valid_i};

   always_comb begin
      src_d[0] = in_data_i;
      for (int k = 1; k < DEPTH; k++) begin
         src_d[k] = d_q[k-1];
      end
   end

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      for (int k = 0; k < DEPTH; k++) begin
         if (rdy[k]) begin
            v_d[k] = chain_v[k];
            // Payload only moves with a valid word so idle stages stay quiet.
            if (chain_v[k]) begin
               d_d[k] = src_d[k];
            end
         end
         // Flush wins over both load and hold; it never feeds back into rdy.
         if (flush_i[k]) begin
            v_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= d_d[k];
         end
      end
   end

   assign in_ready_o  = rdy[0];
   assign out_valid_o = v_q[DEPTH-1];
   assign out_data_o  = d_q[DEPTH-1];

`ifdef PIPE_CHAIN_PERF_EN
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [31:0]      stall_q, stall_d;

   // Occupancy is the popcount of the stage valids that will be present after
   // the edge, so the register tracks v[] without a cycle of lag.
   always_comb begin
      occ_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_d = occ_d + OCC_W'(v_d[k]);
      end
      stall_d = stall_q;
      if (v_q[DEPTH-1] && !out_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         occ_q   <= '0;
         stall_q <= '0;
      end else begin
         occ_q   <= occ_d;
         stall_q <= stall_d;
      end
   end

   assign occupancy_o = occ_q;
   assign stall_cnt_o = stall_q;
`else
   assign occupancy_o = '0;
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_chain
//   Drives a DEPTH=5 and a DEPTH=1 instance of pipe_chain. The DEPTH=5 instance
//   is tracked every cycle by a slot model in which a word advances whenever
//   any slot at or beyond its destination is empty or the head is consumed.
// -----------------------------------------------------------------------------
module tb_pipe_chain;

   localparam int W = 32;
   localparam int D = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DEPTH=5 instance
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  in_data, out_data;
   logic [D-1:0]  flush;
   logic [2:0]    occ;
   logic [31:0]   stall;

   // DEPTH=1 instance
   logic          in_valid1, in_ready1, out_valid1, out_ready1;
   logic [W-1:0]  in_data1, out_data1;
   logic [0:0]    flush1;
   logic [0:0]    occ1;
   logic [31:0]   stall1;

   pipe_chain #(.WIDTH(W), .DEPTH(D)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
      .flush_i(flush), .occupancy_o(occ), .stall_cnt_o(stall)
   );

   pipe_chain #(.WIDTH(W), .DEPTH(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid1), .in_data_i(in_data1), .in_ready_o(in_ready1),
      .out_valid_o(out_valid1), .out_data_o(out_data1), .out_ready_i(out_ready1),
      .flush_i(flush1), .occupancy_o(occ1), .stall_cnt_o(stall1)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit           mv [D];
   logic [W-1:0] md [D];
   logic [31:0]  m_stall;

   function automatic bit room_at(input int k, input bit orr);
      for (int j = k; j < D; j++) begin
         if (!mv[j]) return 1'b1;
      end
      return orr;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int j = 0; j < D; j++) begin
         if (mv[j]) n++;
      end
      return n;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < D; j++) begin
         mv[j] = 1'b0;
         md[j] = '0;
      end
      m_stall = '0;
   endtask

   logic         obs_in_ready, obs_out_valid;
   logic [W-1:0] obs_out_data;

   // One cycle on the DEPTH=5 instance: drive, check against model, clock.
   task automatic tick(input bit iv, input logic [W-1:0] id, input bit orr, input logic [D-1:0] fl);
      bit           nv [D];
      logic [W-1:0] nd [D];
      bit           sv;
      logic [W-1:0] sd;
      bit           stall_inc;
      in_valid  = iv;
      in_data   = id;
      out_ready = orr;
      flush     = fl;
      #1;
      obs_in_ready  = in_ready;
      obs_out_valid = out_valid;
      obs_out_data  = out_data;
      chk("in_ready", 64'(in_ready), 64'(room_at(0, orr)));
      chk("out_valid", 64'(out_valid), 64'(mv[D-1]));
      if (mv[D-1]) chk("out_data", 64'(out_data), 64'(md[D-1]));
`ifdef PIPE_CHAIN_PERF_EN
      chk("occupancy", 64'(occ), 64'(m_count()));
      chk("stall_cnt", 64'(stall), 64'(m_stall));
`else
      chk("occupancy", 64'(occ), 64'(0));
      chk("stall_cnt", 64'(stall), 64'(0));
`endif
      for (int k = 0; k < D; k++) begin
         if (k == 0) begin
            sv = iv;
            sd = id;
         end else begin
            sv = mv[k-1];
            sd = md[k-1];
         end
         nv[k] = mv[k];
         nd[k] = md[k];
         if (room_at(k, orr)) begin
            nv[k] = sv;
            if (sv) nd[k] = sd;
         end
         if (fl[k]) nv[k] = 1'b0;
      end
      stall_inc = mv[D-1] && !orr && (m_stall != 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      for (int k = 0; k < D; k++) begin
         mv[k] = nv[k];
         md[k] = nd[k];
      end
      if (stall_inc) m_stall = m_stall + 32'd1;
   endtask

   logic         obs1_in_ready, obs1_out_valid;
   logic [W-1:0] obs1_out_data;

   task automatic tick1(input bit iv, input logic [W-1:0] id, input bit orr);
      in_valid1  = iv;
      in_data1   = id;
      out_ready1 = orr;
      #1;
      obs1_in_ready  = in_ready1;
      obs1_out_valid = out_valid1;
      obs1_out_data  = out_data1;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      bit           iv;
      logic [W-1:0] id;
      bit           exp_rdy;
      bit           exp_ov;
      logic [W-1:0] exp_od;
   } vec_t;

   vec_t         tbl [8];
   int           idx, nout, fell_at;
   bit           orr_v, iv_v;
   logic [D-1:0] fl_v;
   logic [W-1:0] got [$];
   int           got_c [$];

   initial begin
      rst = 1'b1;
      in_valid = 0; in_data = '0; out_ready = 0; flush = '0;
      in_valid1 = 0; in_data1 = '0; out_ready1 = 0; flush1 = '0;
      model_reset();
      #2;
      // Reset state of both instances
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_occ", 64'(occ), 64'(0));
      chk("rst_stall", 64'(stall), 64'(0));
      chk("rst1_in_ready", 64'(in_ready1), 64'(1));
      chk("rst1_out_valid", 64'(out_valid1), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- latency, DEPTH=5 ----
      tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      for (int i = 1; i < 8; i++) tbl[i] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF};
      for (int i = 0; i < 8; i++) begin
         tick(tbl[i].iv, tbl[i].id, 1'b1, '0);
         chk("lat_in_ready", 64'(obs_in_ready), 64'(tbl[i].exp_rdy));
         chk("lat_out_valid", 64'(obs_out_valid), 64'(tbl[i].exp_ov));
         if (tbl[i].exp_ov) chk("lat_out_data", 64'(obs_out_data), 64'(tbl[i].exp_od));
      end

      // ---- backpressure: stream 0..9, consumer stalled in cycles 3..12 ----
      do_reset();
      idx = 0; nout = 0; fell_at = -1;
      got.delete();
      for (int c = 0; c < 40 && nout < 10; c++) begin
         orr_v = !(c >= 3 && c <= 12);
         iv_v  = (idx < 10);
         tick(iv_v, W'(idx), orr_v, '0);
         if (!obs_in_ready && fell_at < 0) fell_at = idx;
         if (iv_v && obs_in_ready) idx++;
         if (obs_out_valid && orr_v) begin
            got.push_back(obs_out_data);
            nout++;
         end
      end
      chk("bp_ready_fell_at", 64'(fell_at), 64'(5));
      chk("bp_words_out", 64'(nout), 64'(10));
      for (int i = 0; i < got.size(); i++) chk("bp_order", 64'(got[i]), 64'(i));
`ifdef PIPE_CHAIN_PERF_EN
      chk("bp_stall_total", 64'(stall), 64'(8));
`else
      chk("bp_stall_total", 64'(stall), 64'(0));
`endif

      // ---- flush: B killed as it enters stage 1; A, bubble, C ----
      do_reset();
      got.delete(); got_c.delete();
      tick(1'b1, 32'hA, 1'b1, '0);
      tick(1'b1, 32'hB, 1'b1, '0);
      tick(1'b1, 32'hC, 1'b1, 5'b00010);
      for (int c = 3; c < 12; c++) begin
         tick(1'b0, '0, 1'b1, '0);
         if (obs_out_valid) begin
            got.push_back(obs_out_data);
            got_c.push_back(c);
         end
      end
      chk("flush_count", 64'(got.size()), 64'(2));
      if (got.size() == 2) begin
         chk("flush_first", 64'(got[0]), 64'(32'hA));
         chk("flush_second", 64'(got[1]), 64'(32'hC));
         chk("flush_bubble", 64'(got_c[1] - got_c[0]), 64'(2));
         chk("flush_a_cycle", 64'(got_c[0]), 64'(5));
      end

      // ---- full-throughput swap ----
      do_reset();
      got.delete();
      for (int c = 0; c < 5; c++) begin
         tick(1'b1, W'(100 + c), 1'b0, '0);
         chk("fill_in_ready", 64'(obs_in_ready), 64'(1));
      end
      for (int c = 0; c < 20; c++) begin
         tick(1'b1, W'(200 + c), 1'b1, '0);
         chk("swap_in_ready", 64'(obs_in_ready), 64'(1));
         if (obs_out_valid) got.push_back(obs_out_data);
      end
      chk("swap_words_out", 64'(got.size()), 64'(20));
      for (int i = 0; i < got.size(); i++)
         chk("swap_order", 64'(got[i]), 64'((i < 5) ? (100 + i) : (200 + i - 5)));

      // ---- asynchronous reset with 3 words held ----
      do_reset();
      tick(1'b1, 32'h11, 1'b0, '0);
      tick(1'b1, 32'h22, 1'b0, '0);
      tick(1'b1, 32'h33, 1'b0, '0);
      tick(1'b0, '0, 1'b0, '0);
      tick(1'b0, '0, 1'b0, '0);
      tick(1'b0, '0, 1'b0, '0);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("held_out_valid", 64'(out_valid), 64'(1));
      chk("held_out_data", 64'(out_data), 64'(32'h11));
      #1;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'(0));
      chk("arst_occ", 64'(occ), 64'(0));
      chk("arst_stall", 64'(stall), 64'(0));
      chk("arst_in_ready", 64'(in_ready), 64'(1));
      #1;
      rst = 1'b0;
      model_reset();
      tick(1'b0, '0, 1'b0, '0);
      chk("post_rst_in_ready", 64'(obs_in_ready), 64'(1));
      chk("post_rst_out_valid", 64'(obs_out_valid), 64'(0));

      // ---- randomized traffic against the model ----
      do_reset();
      for (int c = 0; c < 400; c++) begin
         fl_v = '0;
         if ($urandom_range(0, 9) == 0) fl_v = D'($urandom_range(0, 31));
         tick($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6, fl_v);
      end

      // ---- DEPTH=1 ----
      do_reset();
      tick1(1'b1, 32'hDEADBEEF, 1'b1);
      chk("d1_c0_in_ready", 64'(obs1_in_ready), 64'(1));
      chk("d1_c0_out_valid", 64'(obs1_out_valid), 64'(0));
      tick1(1'b0, '0, 1'b1);
      chk("d1_c1_out_valid", 64'(obs1_out_valid), 64'(1));
      chk("d1_c1_out_data", 64'(obs1_out_data), 64'(32'hDEADBEEF));
      tick1(1'b0, '0, 1'b1);
      chk("d1_c2_out_valid", 64'(obs1_out_valid), 64'(0));
      for (int c = 0; c < 6; c++) begin
         tick1(1'b1, W'(32'h50 + c), 1'b1);
         chk("d1_b2b_in_ready", 64'(obs1_in_ready), 64'(1));
         chk("d1_b2b_out_valid", 64'(obs1_out_valid), 64'(c > 0));
         if (c > 0) chk("d1_b2b_out_data", 64'(obs1_out_data), 64'(32'h50 + c - 1));
      end
      tick1(1'b1, 32'h99, 1'b0);
      chk("d1_hold_in_ready", 64'(obs1_in_ready), 64'(0));
      chk("d1_hold_out_data", 64'(obs1_out_data), 64'(32'h55));
      tick1(1'b1, 32'h99, 1'b0);
      chk("d1_hold2_out_data", 64'(obs1_out_data), 64'(32'h55));
`ifdef PIPE_CHAIN_PERF_EN
      chk("d1_occ", 64'(occ1), 64'(1));
      chk("d1_stall", 64'(stall1), 64'(2));
`else
      chk("d1_occ", 64'(occ1), 64'(0));
      chk("d1_stall", 64'(stall1), 64'(0));
`endif
      tick1(1'b1, 32'h99, 1'b1);
      chk("d1_release_in_ready", 64'(obs1_in_ready), 64'(1));
      chk("d1_release_out_data", 64'(obs1_out_data), 64'(32'h55));
      tick1(1'b0, '0, 1'b1);
      chk("d1_next_out_data", 64'(obs1_out_data), 64'(32'h99));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
